// File: rtl/vc_distributor_pkg.sv
// Shared link-state encodings, VC indices and defaults for the VC distributor.
package vc_distributor_pkg;

    typedef enum logic [3:0] {
        LINK_RESET  = 4'b0000,
        LINK_INIT   = 4'b0001,
        LINK_IDLE   = 4'b0010,
        LINK_ACTIVE = 4'b0100,
        LINK_ERROR  = 4'b1000
    } link_state_e;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_RUN,
        DS_STALL
    } dist_state_e;

    localparam logic [1:0] VC0 = 2'd0;
    localparam logic [1:0] VC1 = 2'd1;
    localparam logic [1:0] VC2 = 2'd2;
    localparam logic [1:0] VC3 = 2'd3;

    localparam int unsigned LINE_SIZE_DEF = 12;

    function automatic logic [3:0] vc_onehot(input logic [1:0] vc);
        return 4'b0001 << vc;
    endfunction

endpackage

// File: rtl/vc_push_counter.sv
// Wrapping per-VC push counter with enable.
module vc_push_counter #(
    parameter int unsigned CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 en_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/vc_distributor.sv
// Pops words from the upstream FIFO and routes each to its VC FIFO by the top two
// bits, with a one-entry stall buffer for almost-full backpressure.
module vc_distributor
    import vc_distributor_pkg::*;
#(
    parameter int unsigned LINE_SIZE = LINE_SIZE_DEF,
    parameter int unsigned CNT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic [3:0]             state,
    input  logic                   empty_in,
    input  logic [LINE_SIZE-1:0]   data_in,
    input  logic [3:0]             almost_full_signal,
    output logic                   pop_in,
    output logic [3:0]             push_signal,
    output logic [LINE_SIZE-1:0]   data_out,
    output logic [4*CNT_WIDTH-1:0] count_flat,
    output logic                   idle
);

    dist_state_e          st_q, st_d;
    logic [LINE_SIZE-1:0] hold_q, hold_d;
    logic [LINE_SIZE-1:0] data_q, data_d;
    logic [3:0]           push_q, push_d;
    logic                 idle_q, idle_d;

    logic                 in_flight, holding;
    logic [1:0]           in_dest, hold_dest;
    logic                 in_blocked, hold_blocked;

    assign in_flight    = (st_q == DS_RUN);
    assign holding      = (st_q == DS_STALL);
    assign in_dest      = data_in[LINE_SIZE-1 -: 2];
    assign hold_dest    = hold_q[LINE_SIZE-1 -: 2];
    assign in_blocked   = almost_full_signal[in_dest];
    assign hold_blocked = almost_full_signal[hold_dest];

    always_comb begin
        pop_in = reset_L && (state == LINK_ACTIVE) && !empty_in && !holding
                 && !(in_flight && in_blocked);
        st_d   = DS_IDLE;
        hold_d = hold_q;
        data_d = data_q;
        push_d = '0;

        if (in_flight) begin
            if (!in_blocked) begin
                push_d = vc_onehot(in_dest);
                data_d = data_in;
            end else begin
                hold_d = data_in;
                st_d   = DS_STALL;
            end
        end

        if (holding) begin
            if (!hold_blocked) begin
                push_d = vc_onehot(hold_dest);
                data_d = hold_q;
            end else begin
                st_d = DS_STALL;
            end
        end

        // pop_in is already suppressed whenever a word is about to be held
        if (pop_in) begin
            st_d = DS_RUN;
        end

        idle_d = (st_d == DS_IDLE) && (push_d == '0);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            st_q   <= DS_IDLE;
            hold_q <= '0;
            data_q <= '0;
            push_q <= '0;
            idle_q <= 1'b1;
        end else begin
            st_q   <= st_d;
            hold_q <= hold_d;
            data_q <= data_d;
            push_q <= push_d;
            idle_q <= idle_d;
        end
    end

    assign push_signal = push_q;
    assign data_out    = data_q;
    assign idle        = idle_q;

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        vc_push_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk     (clk),
            .reset_L (reset_L),
            .en_i    (push_q[i]),
            .count_o (count_flat[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_vc_distributor.sv
// Scoreboard bench for vc_distributor: upstream FIFO model, expected-push queue, push monitor.
module tb_vc_distributor;

    logic        clk = 1'b0;
    logic        reset_L;
    logic [3:0]  state;
    logic        empty_in;
    logic [11:0] data_in;
    logic [3:0]  almost_full_signal;
    logic        pop_in;
    logic [3:0]  push_signal;
    logic [11:0] data_out;
    logic [19:0] count_flat;
    logic        idle;

    vc_distributor #(.LINE_SIZE(12), .CNT_WIDTH(5)) dut (
        .clk                (clk),
        .reset_L            (reset_L),
        .state              (state),
        .empty_in           (empty_in),
        .data_in            (data_in),
        .almost_full_signal (almost_full_signal),
        .pop_in             (pop_in),
        .push_signal        (push_signal),
        .data_out           (data_out),
        .count_flat         (count_flat),
        .idle               (idle)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          push_total = 0;
    logic        pop_seen = 1'b0;
    logic [11:0] fq[$];
    logic [11:0] exp_q[$];
    int          pop_cyc[$];
    int          push_cyc[$];

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every push must match the head of the expected queue
    always @(negedge clk) begin
        if (push_signal !== 4'b0000) begin
            logic [11:0] e;
            logic [1:0]  v;
            logic [3:0]  oh;
            push_total++;
            push_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_push", {16'h0, push_signal, data_out}, 32'h0);
            end else begin
                e  = exp_q.pop_front();
                v  = e[11:10];
                oh = 4'b0001 << v;
                chk("push_onehot", push_signal, oh);
                chk("push_data", data_out, e);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        pop_seen = pop_in;
        if (pop_seen) pop_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        if (pop_seen && fq.size() > 0) data_in = fq.pop_front();
        empty_in = (fq.size() == 0);
    endtask

    task automatic add(input logic [11:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        empty_in = 1'b0;
    endtask

    task automatic wait_pops(input int n, input string name);
        int g = 0;
        while (pop_cyc.size() < n && g < 100) begin step(); g++; end
        chk(name, pop_cyc.size(), n);
    endtask

    task automatic wait_pushes(input int n, input string name);
        int g = 0;
        while (push_total < n && g < 200) begin step(); g++; end
        chk(name, push_total, n);
    endtask

    initial begin
        int base, drop_cyc;
        reset_L = 1'b0;
        state = 4'b0100;
        almost_full_signal = 4'b0000;
        data_in = 12'h000;
        empty_in = 1'b1;
        add(12'h005); add(12'h40A); add(12'h80F); add(12'hC01);

        // Reset with ACTIVE and non-empty FIFO
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pop_in", pop_in, 1'b0);
        chk("rst_push", push_signal, 4'b0000);
        chk("rst_data_out", data_out, 12'h000);
        chk("rst_counts", count_flat, 20'h0);
        chk("rst_idle", idle, 1'b1);

        @(posedge clk); #1;
        pop_cyc.delete(); push_cyc.delete();
        reset_L = 1'b1;
        step();
        chk("first_pop_after_release", pop_seen, 1'b1);

        // Four-word stream, all VCs open
        wait_pushes(4, "stream_pushes");
        step(); step();
        chk("stream_pop_count", pop_cyc.size(), 4);
        for (int i = 1; i < 4; i++) chk("stream_pop_consecutive", pop_cyc[i], pop_cyc[0] + i);
        for (int i = 0; i < 4; i++) chk("stream_latency", push_cyc[i], pop_cyc[i] + 2);
        chk("stream_counts", count_flat, {5'd1, 5'd1, 5'd1, 5'd1});
        chk("stream_idle", idle, 1'b1);

        // Stall on VC2 with a VC1 word queued behind
        base = push_total;
        pop_cyc.delete(); push_cyc.delete();
        almost_full_signal = 4'b0100;
        add(12'h8AA); add(12'h4BB);
        wait_pops(1, "stall_first_pop");
        repeat (4) step();
        chk("stall_no_pop", pop_cyc.size(), 1);
        chk("stall_no_push", push_total, base);
        chk("stall_not_idle", idle, 1'b0);
        almost_full_signal = 4'b0000;
        drop_cyc = cyc;
        wait_pushes(base + 2, "stall_release_pushes");
        chk("stall_push_timing", push_cyc[0], drop_cyc + 1);
        chk("order_vc1_after_vc2", push_cyc[1] > push_cyc[0], 1'b1);
        chk("pop_resume_not_early", pop_cyc[1] >= push_cyc[0], 1'b1);

        // Leave ACTIVE one cycle after a pop
        repeat (2) step();
        base = push_total;
        pop_cyc.delete();
        add(12'hC11); add(12'hC22);
        wait_pops(1, "inactive_first_pop");
        state = 4'b0001;
        repeat (6) step();
        chk("inactive_no_more_pops", pop_cyc.size(), 1);
        chk("inactive_inflight_pushed", push_total, base + 1);
        void'(fq.pop_back());
        void'(exp_q.pop_back());
        empty_in = (fq.size() == 0);

        // Async reset while a word is held
        state = 4'b0100;
        almost_full_signal = 4'b1000;
        base = push_total;
        pop_cyc.delete();
        add(12'hCEE);
        wait_pops(1, "hold_pop");
        step();
        reset_L = 1'b0;
        #1;
        chk("async_rst_push", push_signal, 4'b0000);
        chk("async_rst_data", data_out, 12'h000);
        chk("async_rst_idle", idle, 1'b1);
        chk("async_rst_pop_in", pop_in, 1'b0);
        chk("async_rst_counts", count_flat, 20'h0);
        void'(exp_q.pop_back());
        almost_full_signal = 4'b0000;
        repeat (3) step();
        reset_L = 1'b1;
        repeat (4) step();
        chk("held_word_discarded", push_total, base);
        chk("post_rst_idle", idle, 1'b1);

        // 33 pushes to VC3 wrap its counter to 1
        base = push_total;
        for (int i = 0; i < 33; i++) add(12'hC00 | 12'(i));
        wait_pushes(base + 33, "wrap_pushes");
        repeat (2) step();
        chk("vc3_wrap_count", count_flat, {5'd1, 5'd0, 5'd0, 5'd0});
        chk("end_idle", idle, 1'b1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
